// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: icache/dcache request ports and the shared RAM port of the memory arbiter.
// master is the arbiter's view; slave is the view of the caches plus RAM model.
interface mem_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between icache and dcache, dcache first with an icache starvation limit.
// Define MEM_ARBITER_STATS_EN to add per-side completed-access counters.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic          CLK,
  input  logic          RST,
  mem_arbiter_if.master bus
`ifdef MEM_ARBITER_STATS_EN
  ,
  output logic [31:0]   stat_dgrants,
  output logic [31:0]   stat_igrants
`endif
);
  localparam int CW = $clog2(STARVE_LIMIT) + 1;
  typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic dreq, access, dg, ig, d_done, i_done, starved, starve_next;
  assign dreq        = bus.dREN | bus.dWEN;
  assign access      = bus.ramstate == 2'd2;
  assign dg          = state_q == DGRANT;
  assign ig          = state_q == IGRANT;
  assign d_done      = dg & access;
  assign i_done      = ig & access;
  assign starved     = int'(starve_q) >= STARVE_LIMIT;
  assign starve_next = int'(starve_q) + 1 >= STARVE_LIMIT;
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = dreq && !(bus.iREN && starved) ? DGRANT : bus.iREN ? IGRANT : IDLE;
      DGRANT:  state_d = access ? (bus.iREN && starve_next ? IGRANT : dreq ? DGRANT : IDLE)
                                : dreq ? DGRANT : IDLE;
      IGRANT:  state_d = access ? (dreq ? DGRANT : bus.iREN ? IGRANT : IDLE)
                                : bus.iREN ? IGRANT : IDLE;
      default: state_d = IDLE;
    endcase
  end
  // counts dcache completions that an icache request has sat through; saturates
  always_comb begin
    starve_d = (!bus.iREN || i_done) ? '0 : (d_done && starve_q != '1) ? starve_q + 1'b1 : starve_q;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end
  always_comb begin
    bus.ramaddr  = dg ? bus.daddr : ig ? bus.iaddr : '0;
    bus.ramstore = dg ? bus.dstore : '0;
    bus.ramWEN   = dg & bus.dWEN;
    bus.ramREN   = dg ? bus.dREN & ~bus.dWEN : ig & bus.iREN;
    bus.dload    = dg ? bus.ramload : '0;
    bus.iload    = ig ? bus.ramload : '0;
    bus.dwait    = dg ? ~access : dreq;
    bus.iwait    = dg | (ig ? ~access : bus.iREN);
  end
`ifdef MEM_ARBITER_STATS_EN
  logic [31:0] dgrants_q, dgrants_d, igrants_q, igrants_d;
  always_comb begin
    dgrants_d = dgrants_q + 32'(d_done);
    igrants_d = igrants_q + 32'(i_done);
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dgrants_q <= '0;
      igrants_q <= '0;
    end else begin
      dgrants_q <= dgrants_d;
      igrants_q <= igrants_d;
    end
  end
  assign stat_dgrants = dgrants_q;
  assign stat_igrants = igrants_q;
`endif
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning max consecutive dcache grants while icache waits.
REQ-002 SHALL have ports CLK in 1 clock; RST in 1 async active-high reset.
REQ-003 SHALL have ports iREN in 1 icache read request; iaddr in 32 icache word address; iwait out 1 icache stall; iload out 32 icache read data.
REQ-004 SHALL have ports dREN in 1, dWEN in 1 dcache read/write request; daddr in 32; dstore in 32; dwait out 1; dload out 32.
REQ-005 SHALL have ports ramREN out 1; ramWEN out 1; ramaddr out 32; ramstore out 32; ramload in 32; ramstate in 2 (0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR).
REQ-006 SHALL have port stat_dgrants out 32 and stat_igrants out 32 (present only per REQ-021).

Function
REQ-007 SHALL implement FSM states IDLE, DGRANT, IGRANT; exactly one requester drives RAM per cycle.
REQ-008 IDLE: ramREN=ramWEN=0, iwait=dwait=1 whenever that side requests; iwait/dwait=0 when no request.
REQ-009 IDLE -> DGRANT when dREN|dWEN and not (iREN and starve count >= STARVE_LIMIT); IDLE -> IGRANT when iREN and no dcache request or starve count >= STARVE_LIMIT; else stay.
REQ-010 DGRANT: ramaddr=daddr, ramstore=dstore, ramREN=dREN, ramWEN=dWEN (dWEN wins if both), dload=ramload; iwait=1.
REQ-011 IGRANT: ramaddr=iaddr, ramREN=iREN, ramWEN=0, iload=ramload; dwait=1 if dcache requests.
REQ-012 Granted side wait SHALL be 0 combinationally in the same cycle ramstate==ACCESS, else 1; FREE, BUSY, ERROR all hold wait=1.
REQ-013 On ACCESS in DGRANT: if iREN and starve count+1 >= STARVE_LIMIT -> IGRANT next; else if dcache still requests -> stay DGRANT (back-to-back burst words, no bubble); else -> IDLE.
REQ-014 On ACCESS in IGRANT: if dcache requests -> DGRANT; else if iREN -> stay IGRANT; else IDLE.
REQ-015 Granted requester dropping its request before ACCESS SHALL return FSM to IDLE next cycle with no RAM strobe that cycle.
REQ-016 Starve counter (width clog2(STARVE_LIMIT)+1, saturating) SHALL increment per completed dcache access while iREN=1, clear on any icache ACCESS or when iREN=0.
REQ-017 iload/dload SHALL be 0 when that side is not granted.
REQ-018 Address/data SHALL pass unmodified; no buffering, single-cycle combinational path ramload->xload.

Reset
REQ-019 RST asserted (any time, incl. mid-access) SHALL force IDLE, starve counter 0, ramREN=ramWEN=0, ramaddr=ramstore=0, within the same cycle asynchronously; waits per REQ-008.
REQ-020 First grant after RST release SHALL occur at the first rising CLK edge with RST low.

Configuration
REQ-021 Macro MEM_ARBITER_STATS_EN defined: stat_dgrants/stat_igrants count completed ACCESS cycles per side, wrap at 2^32, reset to 0; undefined: ports absent, no counters synthesized, arbitration identical.

Verification
REQ-022 Only dREN, daddr=0x40, ramstate ACCESS after 2 BUSY cycles -> ramREN=1, ramaddr=0x40, dwait low exactly in ACCESS cycle, dload=ramload.
REQ-023 dREN and iREN asserted same cycle from IDLE -> DGRANT first, iwait=1 until dcache ACCESS done and dREN drops, then IGRANT.
REQ-024 dcache continuous requests, iREN held, STARVE_LIMIT=4, RAM ACCESS every cycle -> exactly 4 dcache accesses then 1 icache access, repeating.
REQ-025 dWEN=1, dREN=1, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF.
REQ-026 RST pulsed mid-DGRANT with ramstate BUSY -> ramREN=0, ramaddr=0 immediately, state IDLE, starve count 0.
REQ-027 With MEM_ARBITER_STATS_EN, 3 dcache and 2 icache accesses -> stat_dgrants=3, stat_igrants=2.
